// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default bus widths and a
// strobe-width helper used by the interface and the bus initiators.
package axi4_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // One write strobe bit per data byte.
    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle. Every channel follows the usual valid/ready rule:
// a transfer happens on a rising clk edge where valid and ready are both
// high; once raised, valid and its payload hold until that edge.
interface axi4_lite_if
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W
);
    localparam int unsigned STRB_W = strb_w(DATA_W);

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4_lite_simple_master.sv
// Single-outstanding AXI4-Lite initiator. A command accepted on the cmd port
// becomes one read or write transaction; its completion is returned on the
// rsp port. cmd/rsp use valid/ready: a transfer happens on a rising clk edge
// where both are high. A new command may be taken while the previous
// response still waits in the rsp slot; its B/R handshake then stalls until
// the slot has been consumed.
module axi4_lite_simple_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = AXI_ADDR_W,
    parameter int unsigned DATA_BIT_WIDTH = AXI_DATA_W,
    parameter logic [2:0]  AXPROT         = 3'b000
) (
    input  logic                        clk,
    input  logic                        async_rst_n,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [ADDR_BIT_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] cmd_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [DATA_BIT_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,

    output logic                        busy,
    output logic [2:0]                  dbg_state,

    axi4_lite_if.master                 axi
);

    localparam int unsigned STRB_W = strb_w(DATA_BIT_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4
    } mst_state_t;

    mst_state_t                state_q, state_d;
    logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      write_q, write_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;

    // Next-state and next-output logic for the transaction FSM and rsp slot.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        // The rsp slot empties on its own handshake; a completion below may refill it.
        rsp_valid_d = rsp_valid_q && !rsp_ready;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; both low means both are done.
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (axi.bvalid && bready_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = axi.bresp;
                    state_d     = IDLE;
                end
            end
            RD_REQ: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RSP;
                end
            end
            RD_RSP: begin
                if (axi.rvalid && rready_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = write_q;
                    rsp_rdata_d = axi.rdata;
                    rsp_resp_d  = axi.rresp;
                    state_d     = IDLE;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet IDLE.
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        // Registered readies: only take B/R when the rsp slot will be free.
        bready_d = (state_d == WR_RSP) && !rsp_valid_d;
        rready_d = (state_d == RD_RSP) && !rsp_valid_d;
    end

    // State, bus outputs and the response slot, all cleared by async reset.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AXPROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AXPROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_simple_master.sv
// Bench for axi4_lite_simple_master: a behavioural AXI4-Lite slave with
// per-channel ready delays, a response scoreboard and scenario tasks.
module tb_axi4_lite_simple_master;
    import axi4_lite_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int RSP_W   = 1 + DW + 2;
    localparam int TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_ready = 1'b1;
    logic          cmd_ready;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic [2:0]    dbg_state;

    axi4_lite_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi4_lite_simple_master #(
        .ADDR_BIT_WIDTH(AW),
        .DATA_BIT_WIDTH(DW),
        .AXPROT(3'b000)
    ) dut (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .busy(busy),
        .dbg_state(dbg_state),
        .axi(axi)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [RSP_W-1:0] exp_q[$];

    // ---------------- slave model ----------------
    int         aw_delay = 0;
    int         w_delay = 0;
    int         ar_delay = 0;
    logic [1:0] bresp_cfg = OKAY;
    logic [1:0] rresp_cfg = OKAY;
    logic [DW-1:0] slv_mem [0:63];

    int aw_wait, w_wait, ar_wait;
    int aw_wait_last, w_wait_last, ar_wait_last;
    int aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n;
    int proto_err;
    logic aw_done, w_done;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [2:0]    last_awprot;
    logic [DW-1:0] last_wdata;
    logic [SW-1:0] last_wstrb;
    logic          aw_stall, w_stall, ar_stall;
    logic [AW-1:0] aw_stall_addr, ar_stall_addr;
    logic [DW-1:0] w_stall_data;

    assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
    assign axi.wready  = axi.wvalid  && (w_wait  >= w_delay);
    assign axi.arready = axi.arvalid && (ar_wait >= ar_delay);

    wire aw_hs = axi.awvalid && axi.awready;
    wire w_hs  = axi.wvalid  && axi.wready;
    wire ar_hs = axi.arvalid && axi.arready;

    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_wait_last <= 0; w_wait_last <= 0; ar_wait_last <= 0;
            aw_hs_n <= 0; w_hs_n <= 0; b_hs_n <= 0; ar_hs_n <= 0; r_hs_n <= 0;
            aw_done <= 1'b0; w_done <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
            last_awaddr <= '0; last_araddr <= '0; last_awprot <= '0;
            last_wdata <= '0; last_wstrb <= '0;
            aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
            aw_stall_addr <= '0; ar_stall_addr <= '0; w_stall_data <= '0;
        end else begin
            if (aw_hs) begin
                aw_wait <= 0; aw_wait_last <= aw_wait; aw_hs_n <= aw_hs_n + 1;
                last_awaddr <= axi.awaddr; last_awprot <= axi.awprot;
            end else if (axi.awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) begin
                w_wait <= 0; w_wait_last <= w_wait; w_hs_n <= w_hs_n + 1;
                last_wdata <= axi.wdata; last_wstrb <= axi.wstrb;
            end else if (axi.wvalid) w_wait <= w_wait + 1;

            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0; b_hs_n <= b_hs_n + 1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                axi.bvalid <= 1'b1; axi.bresp <= bresp_cfg;
                aw_done <= 1'b0; w_done <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0; r_hs_n <= r_hs_n + 1;
            end
            if (ar_hs) begin
                ar_wait <= 0; ar_wait_last <= ar_wait; ar_hs_n <= ar_hs_n + 1;
                last_araddr <= axi.araddr;
                axi.rvalid <= 1'b1; axi.rresp <= rresp_cfg;
                axi.rdata <= slv_mem[axi.araddr[7:2]];
            end else if (axi.arvalid) ar_wait <= ar_wait + 1;

            // Protocol watch: stalled valids hold with stable payload, and
            // B/R are never accepted while the rsp slot is occupied.
            if (aw_stall && (!axi.awvalid || axi.awaddr != aw_stall_addr)) proto_err <= proto_err + 1;
            else if (w_stall && (!axi.wvalid || axi.wdata != w_stall_data)) proto_err <= proto_err + 1;
            else if (ar_stall && (!axi.arvalid || axi.araddr != ar_stall_addr)) proto_err <= proto_err + 1;
            else if ((axi.bready || axi.rready) && rsp_valid) proto_err <= proto_err + 1;
            aw_stall <= axi.awvalid && !axi.awready; aw_stall_addr <= axi.awaddr;
            w_stall  <= axi.wvalid  && !axi.wready;  w_stall_data  <= axi.wdata;
            ar_stall <= axi.arvalid && !axi.arready; ar_stall_addr <= axi.araddr;
        end
    end

    initial proto_err = 0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                            input logic [1:0] exp_resp, input logic [DW-1:0] exp_rdata,
                            output int unsigned acc_cyc);
        int n;
        n = 0;
        while (!cmd_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 (addr %h)", cmd_ready, addr);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        tick();
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        exp_q.push_back({wr, exp_rdata, exp_resp});
    endtask

    task automatic wait_rsp(input string name, output int unsigned seen_cyc);
        logic [RSP_W-1:0] exp;
        logic [RSP_W-1:0] got;
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
        seen_cyc = cyc;
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_timeout: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, TIMEOUT);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        got = {rsp_write, rsp_rdata, rsp_resp};
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_unexpected: got rsp %h, no response expected", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s_rsp: got write/rdata/resp %h required %h", name, got, exp);
            end
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        async_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_ctrl: cmd_ready/busy/rsp_valid=%b required 100", {cmd_ready, busy, rsp_valid});
        end
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_bus: aw/w/ar valid, b/r ready=%b required 00000",
                     {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
        end
        tests_run++;
        if ({rsp_write, rsp_rdata, rsp_resp, axi.awaddr, axi.wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: rsp_write=%b rsp_rdata=%h rsp_resp=%b awaddr=%h wdata=%h required all 0",
                     rsp_write, rsp_rdata, rsp_resp, axi.awaddr, axi.wdata);
        end
        @(negedge clk);
        async_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        int unsigned acc, seen;
        int b0;
        aw_delay = 0; w_delay = 0; bresp_cfg = OKAY;
        b0 = b_hs_n;
        send_cmd(1'b1, 32'h0, 32'h0000_0001, 4'hF, OKAY, '0, acc);
        wait_rsp("wr_basic", seen);
        tests_run++;
        if (seen - acc != 2) begin
            tests_failed++;
            $display("FAIL wr_latency: rsp_valid %0d edges after accept, required 2", seen - acc);
        end
        tests_run++;
        if ({last_awaddr, last_wdata, last_wstrb, last_awprot} !== {32'h0, 32'h1, 4'hF, 3'b000}) begin
            tests_failed++;
            $display("FAIL wr_bus: awaddr=%h wdata=%h wstrb=%h awprot=%b required 0/1/f/000",
                     last_awaddr, last_wdata, last_wstrb, last_awprot);
        end
        tests_run++;
        if (b_hs_n - b0 != 1) begin
            tests_failed++;
            $display("FAIL wr_b_count: %0d B handshakes, required 1", b_hs_n - b0);
        end
    endtask

    task automatic test_read_wait();
        int unsigned acc, seen;
        ar_delay = 4; rresp_cfg = OKAY;
        slv_mem[3] = 32'h0000_0020;
        send_cmd(1'b0, 32'hC, 32'hFFFF_FFFF, 4'h0, OKAY, 32'h0000_0020, acc);
        wait_rsp("rd_wait", seen);
        tests_run++;
        if (ar_wait_last != 4 || last_araddr !== 32'hC) begin
            tests_failed++;
            $display("FAIL rd_arvalid_hold: wait cycles=%0d araddr=%h required 4 / c", ar_wait_last, last_araddr);
        end
        tests_run++;
        if (seen - acc != 6) begin
            tests_failed++;
            $display("FAIL rd_latency: rsp_valid %0d edges after accept, required 6", seen - acc);
        end
        ar_delay = 0;
    endtask

    task automatic test_split_handshake();
        int aw_tab [3];
        int w_tab [3];
        int unsigned acc, seen;
        int b0, extra;
        logic [DW-1:0] d;
        aw_tab = '{3, 0, 2};
        w_tab  = '{0, 2, 2};
        bresp_cfg = OKAY;
        for (int i = 0; i < 3; i++) begin
            aw_delay = aw_tab[i]; w_delay = w_tab[i];
            d = $urandom;
            b0 = b_hs_n;
            send_cmd(1'b1, 32'h40 + 4 * i, d, 4'h5, OKAY, '0, acc);
            wait_rsp("wr_split", seen);
            tests_run++;
            if (aw_wait_last != aw_tab[i] || w_wait_last != w_tab[i] || last_wdata !== d) begin
                tests_failed++;
                $display("FAIL wr_split_hold[%0d]: aw wait=%0d w wait=%0d wdata=%h required %0d/%0d/%h",
                         i, aw_wait_last, w_wait_last, last_wdata, aw_tab[i], w_tab[i], d);
            end
            tests_run++;
            if (seen - acc != 2 + ((aw_tab[i] > w_tab[i]) ? aw_tab[i] : w_tab[i])) begin
                tests_failed++;
                $display("FAIL wr_split_latency[%0d]: %0d edges after accept", i, seen - acc);
            end
            extra = 0;
            repeat (3) begin
                if (rsp_valid) extra++;
                tick();
            end
            tests_run++;
            if (b_hs_n - b0 != 1 || extra != 0) begin
                tests_failed++;
                $display("FAIL wr_split_once[%0d]: B handshakes=%0d extra rsp cycles=%0d required 1/0",
                         i, b_hs_n - b0, extra);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_error_resp();
        int unsigned acc, seen;
        bresp_cfg = SLVERR;
        send_cmd(1'b1, 32'h100, 32'hCAFE_0001, 4'hF, SLVERR, '0, acc);
        wait_rsp("wr_slverr", seen);
        bresp_cfg = OKAY;
        slv_mem[2] = 32'hDEAD_BEEF;
        send_cmd(1'b0, 32'h8, '0, '0, OKAY, 32'hDEAD_BEEF, acc);
        wait_rsp("rd_after_err", seen);
        rresp_cfg = DECERR;
        slv_mem[4] = 32'h0BAD_0BAD;
        send_cmd(1'b0, 32'h10, '0, '0, DECERR, 32'h0BAD_0BAD, acc);
        wait_rsp("rd_decerr", seen);
        rresp_cfg = OKAY;
    endtask

    task automatic test_back_to_back();
        int unsigned acc, seen;
        int n, r0, rready_hi, moved;
        slv_mem[5] = 32'h1111_1111;
        slv_mem[6] = 32'h2222_2222;
        rsp_ready = 1'b0;
        r0 = r_hs_n;
        send_cmd(1'b0, 32'h14, '0, '0, OKAY, 32'h1111_1111, acc);
        n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
        send_cmd(1'b0, 32'h18, '0, '0, OKAY, 32'h2222_2222, acc);
        rready_hi = 0; moved = 0;
        repeat (4) begin
            if (axi.rready) rready_hi++;
            if (!rsp_valid || rsp_rdata !== 32'h1111_1111) moved++;
            tick();
        end
        tests_run++;
        if (rready_hi != 0 || moved != 0 || r_hs_n - r0 != 1) begin
            tests_failed++;
            $display("FAIL b2b_stall: rready cycles=%0d rsp changes=%0d R handshakes=%0d required 0/0/1",
                     rready_hi, moved, r_hs_n - r0);
        end
        wait_rsp("b2b_first", seen);
        wait_rsp("b2b_second", seen);
    endtask

    task automatic test_reset_mid();
        int unsigned acc, seen;
        aw_delay = 5; w_delay = 5;
        send_cmd(1'b1, 32'h200, 32'h1234_5678, 4'hF, OKAY, '0, acc);
        tick();
        tests_run++;
        if ({busy, axi.awvalid, axi.wvalid} !== 3'b111) begin
            tests_failed++;
            $display("FAIL mid_pre: busy/awvalid/wvalid=%b required 111", {busy, axi.awvalid, axi.wvalid});
        end
        #2;
        async_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, busy, cmd_ready} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL mid_reset: aw/w/ar valid, rsp_valid, busy, cmd_ready=%b required 000001",
                     {axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid, busy, cmd_ready});
        end
        exp_q.delete();
        @(negedge clk);
        async_rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        tick();
        send_cmd(1'b1, 32'h204, 32'h5555_AAAA, 4'hF, OKAY, '0, acc);
        wait_rsp("post_reset_wr", seen);
        tests_run++;
        if (last_awaddr !== 32'h204 || last_wdata !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("FAIL post_reset_bus: awaddr=%h wdata=%h required 204/5555aaaa", last_awaddr, last_wdata);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 64; i++) slv_mem[i] = $urandom;
        test_reset();
        test_write_basic();
        test_read_wait();
        test_split_handshake();
        test_error_resp();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        tests_run++;
        if (proto_err != 0) begin
            tests_failed++;
            $display("FAIL protocol: %0d violations observed, required 0", proto_err);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_simple_master.md
Name: axi4_lite_simple_master

Overview:
AXI4-Lite initiator (master) that turns single-beat commands from a valid/ready command port into AXI4-Lite read or write transactions.
It returns each completion on a valid/ready response port.
It is the driving end for the team's AXI4-Lite register slaves, e.g. the reduction-register block, and replaces bench-only bus driving when the slave must be exercised from RTL.
Only one transaction is outstanding at a time.

Parameters:
ADDR_BIT_WIDTH, 32, AXI4-Lite address width.
DATA_BIT_WIDTH, 32, AXI4-Lite data width; legal values are 32 or 64.
AXPROT, 3'b000, constant value driven on awprot and arprot.

Ports:
clk  in  1  system clock; all logic is rising-edge.
async_rst_n  in  1  asynchronous active-low reset; de-assertion must be synchronised to clk externally.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accept.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_BIT_WIDTH  byte address.
cmd_wdata  in  DATA_BIT_WIDTH  write data; ignored for reads.
cmd_wstrb  in  DATA_BIT_WIDTH/8  write byte strobes; ignored for reads.
rsp_valid  out  1  completion available.
rsp_ready  in  1  completion consumed.
rsp_write  out  1  echoes cmd_write of the completed command.
rsp_rdata  out  DATA_BIT_WIDTH  read data; 0 for writes.
rsp_resp  out  2  bresp or rresp.
busy  out  1  high whenever state != IDLE.
awaddr/awprot/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out; araddr/arprot/arvalid out, arready in; rdata/rresp/rvalid in, rready out. All follow standard AXI4-Lite widths.

Behaviour:
- Reset (async assert):
  - state = IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0.
  - rsp_rdata = 0, rsp_resp = 0, rsp_write = 0.
  - Address and data registers = 0.
  - A reset mid-transaction abandons it; the slave must be reset in the same domain.
- cmd_ready = (state == IDLE), combinational from state only.
- Command accept on cmd_valid & cmd_ready: addr, wdata, wstrb and write are registered.
- Accepted write: next cycle awvalid = wvalid = 1, state = WR_REQ.
- Accepted read: next cycle arvalid = 1, state = RD_REQ.
- WR_REQ:
  - awvalid and wvalid drop independently on their own handshakes (awready or wready sampled high).
  - AW and W may complete in either order or in the same cycle.
  - Once both have completed, including same-cycle completion, go to WR_RSP.
  - Valids never drop before their ready. Address and data stay stable while valid is high.
- WR_RSP: bready = !rsp_valid. On bvalid & bready: rsp_resp = bresp, rsp_rdata = 0, rsp_write = 1, rsp_valid = 1 next cycle, state = IDLE.
- RD_REQ: arvalid held until arready, then state = RD_RSP.
- RD_RSP: rready = !rsp_valid. On rvalid & rready: rsp_rdata = rdata, rsp_resp = rresp, rsp_write = 0, rsp_valid = 1, state = IDLE.
- Response port: rsp_valid is cleared on rsp_ready. rsp fields hold while rsp_valid & !rsp_ready.
- A new command may be accepted while the previous response is still pending.
- Its B/R handshake is blocked by bready/rready low until the response slot frees.
- If the slot frees in the same cycle as bvalid/rvalid, that handshake is not taken that cycle; it happens one cycle later, since bready/rready are registered from rsp_valid.
- Minimum latency, with the slave's ready tied high and rsp_ready = 1:
  - Write: cmd accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2 at the earliest, rsp_valid at cycle 3.
  - Read: the same shape.
- Non-OKAY responses (SLVERR, DECERR) are passed through unchanged. No retry.
- State encoding: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP. Any illegal state returns to IDLE.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - Default ADDR/DATA width constants, aligned with the verification package constants.
- mst_state_t stays local to the module.
- No sub-module; one FSM plus registers.
- The port side bundles onto the existing axi4_lite_if as master.

Test Plan:
- Write addr 0x0, wdata 0x0000_0001, wstrb 0xF; slave all-ready, bresp OKAY -> awaddr 0x0 and wdata 0x1 seen on bus; rsp_valid 3 cycles after accept with rsp_write = 1, rsp_resp = 0.
- Read addr 0xC; slave returns rdata 0x0000_0020 after 4 wait cycles on arready -> arvalid held all 4 cycles; rsp_rdata = 0x20, rsp_resp = 0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid after 4; exactly one B handshake; rsp_valid once.
- Slave returns bresp SLVERR on addr 0x100 -> rsp_resp = 2'b10; the next read command is accepted normally.
- Hold rsp_ready = 0 for 5 cycles after a read, and issue a second read -> second cmd accepted; rready stays 0 until the first response is consumed; both responses arrive in order with correct rdata.
- Assert async_rst_n = 0 while in WR_REQ, off the clock edge -> all valids and rsp_valid are 0 immediately; after release, cmd_ready = 1 and a new write completes normally.
